// File: rtl/dsp48a1_mac_sequencer.sv
// Drives a DSP48A1 slice (A1/B1/M/P/OPMODE registered) through an N-term
// multiply-accumulate job fed from an operand stream; returns the final P.
module dsp48a1_mac_sequencer #(
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [17:0]      S_A,
  input  logic [17:0]      S_B,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic [7:0]       DSP_OPMODE,
  output logic             DSP_CE,
  input  logic [47:0]      P_IN,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [47:0]      RES_DATA,
  output logic             BUSY
);

  localparam int unsigned DRAIN_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [7:0]  OP_FIRST = 8'h01;
  localparam logic [7:0]  OP_ACC   = 8'h09;
  localparam logic [7:0]  OP_HOLD  = 8'h08;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   cnt_inc;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               slot_v_q, slot_v_d;
  logic               slot_f_q, slot_f_d;
  logic               s_ready_d, ce_d, res_valid_d, busy_d;
  logic [17:0]        a_d, b_d;
  logic [7:0]         opmode_d;
  logic [47:0]        res_data_d;

  assign cnt_inc = cnt_q + LEN_W'(1);

  // Next-state and next-output decode; the slot tag lags the operands one edge
  // to line up with the slice's A1/B1 -> M stage.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    slot_v_d    = 1'b0;
    slot_f_d    = 1'b0;
    s_ready_d   = S_READY;
    ce_d        = DSP_CE;
    res_valid_d = RES_VALID;
    res_data_d  = RES_DATA;
    a_d         = DSP_A;
    b_d         = DSP_B;
    opmode_d    = slot_v_q ? (slot_f_q ? OP_FIRST : OP_ACC) : OP_HOLD;

    unique case (state_q)
      ST_IDLE: begin
        opmode_d = OP_HOLD;
        if (START) begin
          if (LEN != '0) begin
            len_d     = LEN;
            cnt_d     = '0;
            s_ready_d = 1'b1;
            ce_d      = 1'b1;
            state_d   = ST_ACCUM;
          end else begin
            res_data_d  = '0;
            res_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_ACCUM: begin
        if (S_VALID && S_READY) begin
          a_d      = S_A;
          b_d      = S_B;
          slot_v_d = 1'b1;
          slot_f_d = (cnt_q == '0);
          cnt_d    = cnt_inc;
          if (cnt_inc == len_q) begin
            s_ready_d = 1'b0;
            drain_d   = '0;
            state_d   = ST_DRAIN;
          end
        end else begin
          a_d = '0;
          b_d = '0;
        end
      end
      ST_DRAIN: begin
        a_d = '0;
        b_d = '0;
        if (drain_q == DRAIN_W'(PIPE_LAT)) begin
          res_data_d  = P_IN;
          res_valid_d = 1'b1;
          ce_d        = 1'b0;
          state_d     = ST_DONE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      ST_DONE: begin
        opmode_d = OP_HOLD;
        if (RES_READY) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      drain_q    <= '0;
      slot_v_q   <= 1'b0;
      slot_f_q   <= 1'b0;
      S_READY    <= 1'b0;
      DSP_CE     <= 1'b0;
      RES_VALID  <= 1'b0;
      RES_DATA   <= '0;
      DSP_A      <= '0;
      DSP_B      <= '0;
      DSP_OPMODE <= OP_HOLD;
      BUSY       <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      slot_v_q   <= slot_v_d;
      slot_f_q   <= slot_f_d;
      S_READY    <= s_ready_d;
      DSP_CE     <= ce_d;
      RES_VALID  <= res_valid_d;
      RES_DATA   <= res_data_d;
      DSP_A      <= a_d;
      DSP_B      <= b_d;
      DSP_OPMODE <= opmode_d;
      BUSY       <= busy_d;
    end
  end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Directed bench for dsp48a1_mac_sequencer with a behavioural DSP48A1 slice
// (A1/B1/M/P/OPMODE registers sharing one clock enable).
module tb_dsp48a1_mac_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [15:0] LEN = '0;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic [17:0] S_A = '0;
  logic [17:0] S_B = '0;
  logic [17:0] DSP_A, DSP_B;
  logic [7:0]  DSP_OPMODE;
  logic        DSP_CE;
  logic [47:0] P_IN;
  logic        RES_VALID;
  logic        RES_READY = 1'b0;
  logic [47:0] RES_DATA;
  logic        BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  dsp48a1_mac_sequencer #(.LEN_W(16), .PIPE_LAT(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .LEN(LEN),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_A(S_A), .S_B(S_B),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE), .DSP_CE(DSP_CE),
    .P_IN(P_IN), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_DATA(RES_DATA), .BUSY(BUSY)
  );

  // Slice model: signed 18x18 into M, X/Z mux from the registered OPMODE.
  logic signed [17:0] a1 = '0, b1 = '0;
  logic signed [35:0] m_reg = '0;
  logic [7:0]         op_reg = 8'h08;
  logic [47:0]        p_reg = '0;
  logic [47:0]        x_mux, z_mux;
  assign x_mux = (op_reg[1:0] == 2'b01) ? {{12{m_reg[35]}}, m_reg} : 48'd0;
  assign z_mux = (op_reg[3:2] == 2'b10) ? p_reg : 48'd0;
  assign P_IN  = p_reg;
  always @(posedge CLK) begin
    if (DSP_CE) begin
      a1     <= DSP_A;
      b1     <= DSP_B;
      m_reg  <= a1 * b1;
      op_reg <= DSP_OPMODE;
      p_reg  <= x_mux + z_mux;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic start_job(input logic [15:0] len);
    START = 1'b1;
    LEN   = len;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic send_beat(input logic [17:0] a, input logic [17:0] b);
    S_VALID = 1'b1;
    S_A     = a;
    S_B     = b;
    @(negedge CLK);
    S_VALID = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!RES_VALID && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic ack;
    RES_READY = 1'b1;
    @(negedge CLK);
    RES_READY = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge CLK);
    n_tests++;
    if ({S_READY, RES_VALID, BUSY, DSP_CE} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0000", {S_READY, RES_VALID, BUSY, DSP_CE});
    end
    n_tests++;
    if ({DSP_OPMODE, DSP_A, DSP_B, RES_DATA} !== {8'h08, 18'd0, 18'd0, 48'd0}) begin
      n_fail++;
      $display("FAIL reset_data: got op=%h a=%h b=%h res=%h required op=08 a=0 b=0 res=0",
               DSP_OPMODE, DSP_A, DSP_B, RES_DATA);
    end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    start_job(16'd3);
    n_tests++;
    if ({S_READY, DSP_CE, BUSY} !== 3'b111) begin
      n_fail++; $display("FAIL b2b_accum_entry: got %b required 111", {S_READY, DSP_CE, BUSY});
    end
    S_VALID = 1'b1; S_A = 18'd2; S_B = 18'd3;
    @(negedge CLK);
    n_tests++;
    if ({DSP_A, DSP_OPMODE} !== {18'd2, 8'h08}) begin
      n_fail++; $display("FAIL b2b_beat0: got a=%0d op=%h required a=2 op=08", DSP_A, DSP_OPMODE);
    end
    S_A = 18'd4; S_B = 18'd5;
    @(negedge CLK);
    n_tests++;
    if (DSP_OPMODE !== 8'h01) begin
      n_fail++; $display("FAIL b2b_op_first: got %h required 01", DSP_OPMODE);
    end
    S_A = 18'd6; S_B = 18'd7;
    @(negedge CLK);
    S_VALID = 1'b0;
    n_tests++;
    if ({S_READY, DSP_OPMODE} !== {1'b0, 8'h09}) begin
      n_fail++; $display("FAIL b2b_last: got rdy=%b op=%h required rdy=0 op=09", S_READY, DSP_OPMODE);
    end
    @(negedge CLK);
    n_tests++;
    if ({RES_VALID, DSP_OPMODE} !== {1'b0, 8'h09}) begin
      n_fail++; $display("FAIL b2b_op_acc2: got rv=%b op=%h required rv=0 op=09", RES_VALID, DSP_OPMODE);
    end
    @(negedge CLK);
    n_tests++;
    if ({RES_VALID, DSP_OPMODE} !== {1'b0, 8'h08}) begin
      n_fail++; $display("FAIL b2b_op_hold: got rv=%b op=%h required rv=0 op=08", RES_VALID, DSP_OPMODE);
    end
    @(negedge CLK);
    n_tests++;
    if (RES_VALID !== 1'b0) begin
      n_fail++; $display("FAIL b2b_early_valid: got %b required 0", RES_VALID);
    end
    @(negedge CLK);
    n_tests++;
    if ({RES_VALID, RES_DATA} !== {1'b1, 48'd68}) begin
      n_fail++; $display("FAIL b2b_result: got rv=%b data=%0d required rv=1 data=68", RES_VALID, RES_DATA);
    end
    ack();
    n_tests++;
    if ({RES_VALID, BUSY} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_handshake: got %b required 00", {RES_VALID, BUSY});
    end
  endtask

  task automatic test_bubbles;
    int cyc;
    start_job(16'd2);
    send_beat(18'd10, 18'd10);
    @(negedge CLK);
    n_tests++;
    if (DSP_OPMODE !== 8'h01) begin
      n_fail++; $display("FAIL gap_op_first: got %h required 01", DSP_OPMODE);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_tests++;
      if (DSP_OPMODE !== 8'h08) begin
        n_fail++; $display("FAIL gap_op_hold%0d: got %h required 08", i, DSP_OPMODE);
      end
    end
    send_beat(18'd1, 18'd1);
    wait_result(cyc);
    n_tests++;
    if (cyc !== 4) begin
      n_fail++; $display("FAIL gap_latency: got %0d required 4", cyc);
    end
    n_tests++;
    if (RES_DATA !== 48'd101) begin
      n_fail++; $display("FAIL gap_result: got %0d required 101", RES_DATA);
    end
    ack();
  endtask

  task automatic test_len_zero;
    START = 1'b1; LEN = 16'd0;
    @(negedge CLK);
    START = 1'b0;
    n_tests++;
    if ({RES_VALID, RES_DATA, S_READY, DSP_CE} !== {1'b1, 48'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL len0_done: got rv=%b data=%0d rdy=%b ce=%b required rv=1 data=0 rdy=0 ce=0",
                         RES_VALID, RES_DATA, S_READY, DSP_CE);
    end
    @(negedge CLK);
    n_tests++;
    if ({S_READY, DSP_CE, RES_VALID} !== 3'b001) begin
      n_fail++; $display("FAIL len0_hold: got %b required 001", {S_READY, DSP_CE, RES_VALID});
    end
    ack();
    n_tests++;
    if ({BUSY, RES_VALID, S_READY, DSP_CE} !== 4'b0000) begin
      n_fail++; $display("FAIL len0_idle: got %b required 0000", {BUSY, RES_VALID, S_READY, DSP_CE});
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    start_job(16'd1);
    send_beat(18'd9, 18'd9);
    wait_result(cyc);
    n_tests++;
    if ({RES_VALID, RES_DATA} !== {1'b1, 48'd81}) begin
      n_fail++; $display("FAIL bp_result: got rv=%b data=%0d required rv=1 data=81", RES_VALID, RES_DATA);
    end
    for (int i = 0; i < 5; i++) begin
      START = (i % 2 == 0);
      LEN   = 16'd2;
      @(negedge CLK);
      n_tests++;
      if ({RES_VALID, RES_DATA, S_READY, DSP_CE, BUSY} !== {1'b1, 48'd81, 1'b0, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL bp_stall%0d: got rv=%b data=%0d rdy=%b ce=%b busy=%b required 1,81,0,0,1",
                           i, RES_VALID, RES_DATA, S_READY, DSP_CE, BUSY);
      end
    end
    START = 1'b0;
    ack();
    n_tests++;
    if ({RES_VALID, BUSY} !== 2'b00) begin
      n_fail++; $display("FAIL bp_release: got %b required 00", {RES_VALID, BUSY});
    end
    @(negedge CLK);
    n_tests++;
    if ({BUSY, S_READY} !== 2'b00) begin
      n_fail++; $display("FAIL bp_start_ignored: got %b required 00", {BUSY, S_READY});
    end
  endtask

  task automatic test_reset_midjob;
    int cyc;
    start_job(16'd4);
    send_beat(18'd1, 18'd2);
    send_beat(18'd3, 18'd4);
    #2 RST_N = 1'b0;
    #1;
    n_tests++;
    if ({S_READY, RES_VALID, BUSY, DSP_CE, DSP_OPMODE, DSP_A, DSP_B, RES_DATA} !==
        {4'b0000, 8'h08, 18'd0, 18'd0, 48'd0}) begin
      n_fail++; $display("FAIL rst_async: got ctl=%b op=%h a=%h b=%h res=%h required ctl=0000 op=08 a=0 b=0 res=0",
                         {S_READY, RES_VALID, BUSY, DSP_CE}, DSP_OPMODE, DSP_A, DSP_B, RES_DATA);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (BUSY !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: got busy=%b required 0", BUSY);
    end
    start_job(16'd1);
    send_beat(18'd3, 18'h3FFFE);
    wait_result(cyc);
    // 3 * -2 = -6 as a 48-bit two's-complement value
    n_tests++;
    if ({RES_VALID, RES_DATA} !== {1'b1, 48'hFFFF_FFFF_FFFA}) begin
      n_fail++; $display("FAIL rst_newjob: got rv=%b data=%h required rv=1 data=fffffffffffa", RES_VALID, RES_DATA);
    end
    ack();
  endtask

  task automatic test_first_clears;
    int cyc;
    start_job(16'd1);
    send_beat(18'd5, 18'd5);
    wait_result(cyc);
    n_tests++;
    if (RES_DATA !== 48'd25) begin
      n_fail++; $display("FAIL clr_job1: got %0d required 25", RES_DATA);
    end
    ack();
    start_job(16'd1);
    send_beat(18'd1, 18'd1);
    wait_result(cyc);
    n_tests++;
    if ({RES_VALID, RES_DATA} !== {1'b1, 48'd1}) begin
      n_fail++; $display("FAIL clr_job2: got rv=%b data=%0d required rv=1 data=1", RES_VALID, RES_DATA);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_len_zero();
    test_backpressure();
    test_reset_midjob();
    test_first_clears();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
